// File: rtl/portb_arbiter_if.sv
// Port-B sharing bundle: two requester channels plus the RAM port-B side.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface portb_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0;
  logic          lock0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          lock1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] addressB;
  logic [DW-1:0] writeDataB;
  logic          writeEnableB;
  logic [DW-1:0] readDataB;

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    input  readDataB,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output addressB, writeDataB, writeEnableB
  );

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    output readDataB,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  addressB, writeDataB, writeEnableB
  );
endinterface

// File: rtl/portb_arbiter.sv
// Two-requester arbiter for text/glyph RAM port B: round-robin or fixed priority,
// optional lock for read-modify-write, and tagged read-data return after RD_LAT cycles.
module portb_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1,
  parameter int PRIO0  = 0
) (
  input logic             clk,
  input logic             rst,
  portb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED_0,
    LOCKED_1
  } lockState_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rdTag_t;

  lockState_t    lockState;
  logic          last;
  rdTag_t        rdPipe [RD_LAT];
  logic [AW-1:0] addrHold;

  logic          gnt0;
  logic          gnt1;
  logic          gntAny;
  logic [AW-1:0] addrSel;
  logic [DW-1:0] wdataSel;
  rdTag_t        rdPush;
  rdTag_t        rdOut;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (lockState)
        LOCKED_0: gnt0 = bus.req0;
        LOCKED_1: gnt1 = bus.req1;
        default: begin
          if (bus.req0 && bus.req1) begin
            // last == 1 means requester 1 was served most recently, so 0 goes next
            if (PRIO0 != 0 || last) gnt0 = 1'b1;
            else                    gnt1 = 1'b1;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
      endcase
    end
  end

  assign gntAny = gnt0 | gnt1;

  always_comb begin
    addrSel  = addrHold;
    wdataSel = '0;
    if (gnt1) begin
      addrSel  = bus.addr1;
      wdataSel = bus.wdata1;
    end else if (gnt0) begin
      addrSel  = bus.addr0;
      wdataSel = bus.wdata0;
    end
  end

  assign rdPush.valid = (gnt0 & ~bus.we0) | (gnt1 & ~bus.we1);
  assign rdPush.id    = gnt1;
  assign rdOut        = rdPipe[RD_LAT-1];

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.addressB     = addrSel;
  assign bus.writeDataB   = wdataSel;
  assign bus.writeEnableB = (gnt0 & bus.we0) | (gnt1 & bus.we1);

  // Read return is gated by rst so in-flight data never surfaces during reset.
  assign bus.rvalid0 = ~rst & rdOut.valid & ~rdOut.id;
  assign bus.rvalid1 = ~rst & rdOut.valid &  rdOut.id;
  assign bus.rdata0  = bus.rvalid0 ? bus.readDataB : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.readDataB : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lockState <= UNLOCKED;
      last      <= 1'b1;
      addrHold  <= '0;
      // NOTE: the read-tag pipe is reset on purpose: its valid bits decide whether rvalid fires.
      for (int i = 0; i < RD_LAT; i++) rdPipe[i] <= '0;
    end else begin
      if (gntAny) begin
        last     <= gnt1;
        addrHold <= addrSel;
      end

      rdPipe[0] <= rdPush;
      for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];

      case (lockState)
        UNLOCKED: begin
          if (gnt0 && bus.lock0)      lockState <= LOCKED_0;
          else if (gnt1 && bus.lock1) lockState <= LOCKED_1;
        end
        LOCKED_0: if (!bus.req0 || !bus.lock0) lockState <= UNLOCKED;
        LOCKED_1: if (!bus.req1 || !bus.lock1) lockState <= UNLOCKED;
        default:  lockState <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_portb_arbiter.sv
// Scoreboard bench for portb_arbiter: a round-robin RD_LAT=1 instance and a fixed-priority
// RD_LAT=2 instance share one stimulus stream; sel picks the instance being observed.
module tb_portb_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  portb_arbiter_if #(.AW(AW), .DW(DW)) busA ();
  portb_arbiter_if #(.AW(AW), .DW(DW)) busP ();

  portb_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .PRIO0(0)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  portb_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .PRIO0(1)) dutP (
    .clk (clk),
    .rst (rst),
    .bus (busP)
  );

  logic sel = 1'b0;
  int   lat = 1;

  logic          gnt0, gnt1, rvalid0, rvalid1, writeEnableB;
  logic [DW-1:0] rdata0, rdata1, writeDataB;
  logic [AW-1:0] addressB;

  assign gnt0         = sel ? busP.gnt0         : busA.gnt0;
  assign gnt1         = sel ? busP.gnt1         : busA.gnt1;
  assign rvalid0      = sel ? busP.rvalid0      : busA.rvalid0;
  assign rvalid1      = sel ? busP.rvalid1      : busA.rvalid1;
  assign rdata0       = sel ? busP.rdata0       : busA.rdata0;
  assign rdata1       = sel ? busP.rdata1       : busA.rdata1;
  assign addressB     = sel ? busP.addressB     : busA.addressB;
  assign writeDataB   = sel ? busP.writeDataB   : busA.writeDataB;
  assign writeEnableB = sel ? busP.writeEnableB : busA.writeEnableB;

  // Write-first RAM model with one- and two-cycle read taps.
  logic [DW-1:0] mem    [65536];
  logic [DW-1:0] shadow [65536];
  logic [DW-1:0] rd1, rd2;

  always @(posedge clk) begin
    if (writeEnableB) mem[addressB] <= writeDataB;
    rd1 <= writeEnableB ? writeDataB : mem[addressB];
    rd2 <= rd1;
  end

  assign busA.readDataB = rd1;
  assign busP.readDataB = rd2;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } rdExp_t;

  rdExp_t sb [$];
  rdExp_t e;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic          tWe0, tWe1;
  logic [AW-1:0] tAddr0, tAddr1;
  logic [DW-1:0] tWd0, tWd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic r0, input logic l0, input logic w0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic l1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    tWe0 = w0; tAddr0 = a0; tWd0 = d0;
    tWe1 = w1; tAddr1 = a1; tWd1 = d1;
    busA.req0 = r0; busA.lock0 = l0; busA.we0 = w0; busA.addr0 = a0; busA.wdata0 = d0;
    busA.req1 = r1; busA.lock1 = l1; busA.we1 = w1; busA.addr1 = a1; busA.wdata1 = d1;
    busP.req0 = r0; busP.lock0 = l0; busP.we0 = w0; busP.addr0 = a0; busP.wdata0 = d0;
    busP.req1 = r1; busP.lock1 = l1; busP.we1 = w1; busP.addr1 = a1; busP.wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // Check one cycle's grant and port-B drive, then record what the RAM should return.
  task automatic step(input bit e0, input bit e1, input string tag);
    @(negedge clk);
    check({tag, ".gnt0"}, gnt0, e0);
    check({tag, ".gnt1"}, gnt1, e1);
    check({tag, ".we"}, writeEnableB, (e0 & tWe0) | (e1 & tWe1));
    if (e1) begin
      check({tag, ".addr"}, addressB, tAddr1);
      check({tag, ".wdata"}, writeDataB, tWd1);
    end else if (e0) begin
      check({tag, ".addr"}, addressB, tAddr0);
      check({tag, ".wdata"}, writeDataB, tWd0);
    end else begin
      check({tag, ".wdata_idle"}, writeDataB, 0);
    end
    if (rst) begin
      check({tag, ".rst_rvalid"}, {rvalid1, rvalid0}, 0);
      check({tag, ".rst_rdata0"}, rdata0, 0);
      check({tag, ".rst_rdata1"}, rdata1, 0);
    end
    if (e0) begin
      if (tWe0) shadow[tAddr0] = tWd0;
      else sb.push_back('{1'b0, shadow[tAddr0], cyc + lat});
    end
    if (e1) begin
      if (tWe1) shadow[tAddr1] = tWd1;
      else sb.push_back('{1'b1, shadow[tAddr1], cyc + lat});
    end
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      check("rvalid_excl", {31'd0, rvalid0 & rvalid1}, 0);
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {rvalid1, rvalid0}, 0);
      end else begin
        e = sb.pop_front();
        check("rd_id", rvalid1, e.id);
        check("rd_cycle", cyc, e.due);
        check("rd_data", rvalid1 ? rdata1 : rdata0, e.data);
        check("rd_other_zero", rvalid1 ? rdata0 : rdata1, 0);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("rvalid_missing", 0, 1);
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = DW'(i) ^ 16'hC3A5;
      shadow[i] = DW'(i) ^ 16'hC3A5;
    end
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Requests during reset are never granted.
    drive(1, 0, 0, 16'h0001, '0, 1, 0, 1, 16'h0002, 16'hFFFF);
    step(0, 0, "rstA");
    rst = 1'b0;

    // Single read by requester 0.
    drive(1, 0, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
    step(1, 0, "single");
    idle();
    step(0, 0, "single_idle");

    // Round-robin: last = 0, so requester 1 goes first.
    drive(1, 0, 0, 16'h0020, '0, 1, 0, 0, 16'h0030, '0);
    for (int i = 0; i < 6; i++) step(i % 2 == 1, i % 2 == 0, "rr");
    idle();
    step(0, 0, "rr_idle");

    // lock0 without req0 has no effect.
    drive(0, 1, 0, '0, '0, 1, 0, 0, 16'h0040, '0);
    step(0, 1, "nolock0");
    step(0, 1, "nolock1");

    // Requester 1 read-modify-write under lock while requester 0 waits.
    drive(1, 0, 0, 16'h0050, '0, 0, 0, 0, '0, '0);
    step(1, 0, "lk_pre");
    drive(1, 0, 0, 16'h0100, '0, 1, 1, 0, 16'h0100, '0);
    step(0, 1, "lk_c0");
    drive(1, 0, 0, 16'h0100, '0, 1, 0, 1, 16'h0100, 16'hABCD);
    step(0, 1, "lk_c1");
    drive(1, 0, 0, 16'h0100, '0, 0, 0, 0, '0, '0);
    step(1, 0, "lk_c2");
    idle();
    step(0, 0, "lk_idle");

    // Requester 0 holds its lock for several cycles against a waiting requester 1.
    drive(0, 0, 0, '0, '0, 1, 0, 0, 16'h0070, '0);
    step(0, 1, "lk0_pre");
    drive(1, 1, 0, 16'h0060, '0, 1, 0, 0, 16'h0070, '0);
    step(1, 0, "lk0_c0");
    step(1, 0, "lk0_c1");
    step(1, 0, "lk0_c2");
    drive(1, 0, 1, 16'h0060, 16'h5555, 1, 0, 0, 16'h0070, '0);
    step(1, 0, "lk0_rel");
    drive(0, 0, 0, '0, '0, 1, 0, 0, 16'h0060, '0);
    step(0, 1, "lk0_after");

    // Write by requester 0 followed immediately by a read of the same address by requester 1.
    drive(1, 0, 1, 16'h0005, 16'h1234, 0, 0, 0, '0, '0);
    step(1, 0, "wr0");
    drive(0, 0, 0, '0, '0, 1, 0, 0, 16'h0005, '0);
    step(0, 1, "rd1");
    idle();
    step(0, 0, "wr_idle0");
    step(0, 0, "wr_idle1");

    // Switch to the fixed-priority, two-cycle-latency instance.
    rst = 1'b1;
    step(0, 0, "rstP0");
    sel = 1'b1;
    lat = 2;
    step(0, 0, "rstP1");
    rst = 1'b0;

    drive(1, 0, 0, 16'h0020, '0, 1, 0, 0, 16'h0030, '0);
    for (int i = 0; i < 5; i++) step(1, 0, "prio");
    drive(0, 0, 0, '0, '0, 1, 0, 0, 16'h0030, '0);
    step(0, 1, "prio_drop");
    idle();
    repeat (3) step(0, 0, "prio_idle");

    // Reset while two reads are in flight: both are dropped.
    drive(1, 0, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
    step(1, 0, "mid_rd0");
    drive(1, 0, 0, 16'h0011, '0, 0, 0, 0, '0, '0);
    step(1, 0, "mid_rd1");
    rst = 1'b1;
    sb.delete();
    drive(1, 0, 0, 16'h0012, '0, 1, 0, 1, 16'h0013, 16'h9999);
    step(0, 0, "mid_rst");
    rst = 1'b0;
    drive(1, 0, 0, 16'h0012, '0, 1, 0, 0, 16'h0013, '0);
    step(1, 0, "resume0");
    drive(0, 0, 0, '0, '0, 1, 0, 0, 16'h0013, '0);
    step(0, 1, "resume1");
    idle();
    repeat (3) step(0, 0, "end_idle");

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
